// File: rtl/tlb_miss_ram_arbiter.sv
// Two-master arbiter for port s1 of the TLB-miss handler RAM: m0 has fixed priority,
// m1 gets a forced grant after STARVE_LIMIT consecutive denied cycles.
module tlb_miss_ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int BE_W         = DATA_W/8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       req0, req1, force1, grant0, grant1;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_owner_q, rd_owner_d;

  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    force1 = req1 & (starve_cnt_q == LIMIT);
    grant1 = req1 & (~req0 | force1);
    grant0 = req0 & ~force1;

    m0_waitrequest = ~grant0;
    m1_waitrequest = ~grant1;

    // Idle bus still presents m0's fields; only write and chipselect are gated.
    ram_chipselect = grant0 | grant1;
    ram_address    = grant1 ? m1_address    : m0_address;
    ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
    ram_write      = (grant0 & m0_write) | (grant1 & m1_write);
    ram_clken      = 1'b1;

    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    m1_readdatavalid = rd_vld_q & rd_owner_q;

    rd_vld_d   = (grant0 & m0_read) | (grant1 & m1_read);
    rd_owner_d = rd_vld_d ? grant1 : rd_owner_q;

    starve_cnt_d = starve_cnt_q;
    if (grant1 || !req1)
      starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT)
      starve_cnt_d = starve_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q     <= 1'b0;
      rd_owner_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      rd_vld_q     <= rd_vld_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
endmodule

// File: tb/tb_tlb_miss_ram_arbiter.sv
// Bench: two arbiter instances (STARVE_LIMIT 4 and 1) share master stimulus, each with
// its own RAM and a cycle-level reference model; directed plan items plus random traffic.
module tb_tlb_miss_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;

  logic        m0_wait [2];
  logic        m1_wait [2];
  logic        m0_rdv  [2];
  logic        m1_rdv  [2];
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h20:    return 32'h11223344;
      default: return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LIM = (g == 0) ? 4 : 1;
    logic [7:0]  ram_addr;
    logic        ram_cs, ram_wr, ram_ce;
    logic [3:0]  ram_be;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd = '0;
    logic [31:0] mem [256];
    bit          ram_init = 1'b0;

    tlb_miss_ram_arbiter #(.ADDR_W(8), .DATA_W(32), .BE_W(4), .STARVE_LIMIT(LIM)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_wait[g]), .m0_readdata(m0_rdata[g]), .m0_readdatavalid(m0_rdv[g]),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_wait[g]), .m1_readdata(m1_rdata[g]), .m1_readdatavalid(m1_rdv[g]),
      .ram_address(ram_addr), .ram_chipselect(ram_cs), .ram_write(ram_wr),
      .ram_byteenable(ram_be), .ram_writedata(ram_wd), .ram_clken(ram_ce),
      .ram_readdata(ram_rd)
    );

    // RAM port s1: registered read, byte-lane writes.
    always @(posedge clk) begin
      if (!ram_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        ram_init <= 1'b1;
      end else if (ram_cs) begin
        ram_rd <= mem[ram_addr];
        if (ram_wr)
          for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
      end
    end

    // Reference model: denied-cycle count, one pending read, shadow memory.
    int          denied = 0;
    bit          pend = 1'b0, pown = 1'b0, minit = 1'b0;
    logic [31:0] pdata = '0;
    logic [31:0] rmem [256];

    always @(negedge clk) begin
      bit r0, r1, e0, e1, wr;
      logic [7:0]  a;
      logic [3:0]  be;
      logic [31:0] wd;
      if (!minit) begin
        for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
        minit = 1'b1;
      end
      if (!reset_n) begin
        pend   = 1'b0;
        denied = 0;
      end
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      e1 = r1 && (!r0 || denied == LIM);
      e0 = r0 && !e1;
      a  = e1 ? m1_address    : m0_address;
      be = e1 ? m1_byteenable : m0_byteenable;
      wd = e1 ? m1_writedata  : m0_writedata;
      wr = e1 ? m1_write      : (e0 && m0_write);

      chk($sformatf("i%0d.wait0", g), 32'(m0_wait[g]), 32'(!e0));
      chk($sformatf("i%0d.wait1", g), 32'(m1_wait[g]), 32'(!e1));
      chk($sformatf("i%0d.cs", g),    32'(ram_cs), 32'(e0 || e1));
      chk($sformatf("i%0d.wr", g),    32'(ram_wr), 32'(wr));
      chk($sformatf("i%0d.clken", g), 32'(ram_ce), 32'd1);
      chk($sformatf("i%0d.addr", g),  32'(ram_addr), 32'(a));
      if (e0 || e1) begin
        chk($sformatf("i%0d.be", g), 32'(ram_be), 32'(be));
        chk($sformatf("i%0d.wd", g), ram_wd, wd);
      end
      chk($sformatf("i%0d.rdv0", g), 32'(m0_rdv[g]), 32'(pend && !pown));
      chk($sformatf("i%0d.rdv1", g), 32'(m1_rdv[g]), 32'(pend && pown));
      if (pend) chk($sformatf("i%0d.rdata", g), pown ? m1_rdata[g] : m0_rdata[g], pdata);

      // Advance to the state seen after the coming rising edge.
      if (reset_n) begin
        pend   = (e0 && m0_read) || (e1 && m1_read);
        pown   = e1;
        pdata  = rmem[a];
        denied = (e1 || !r1) ? 0 : ((denied < LIM) ? denied + 1 : denied);
      end
      if (wr)
        for (int b = 0; b < 4; b++)
          if (be[b]) rmem[a][b*8 +: 8] = wd[b*8 +: 8];
    end
  end

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    m0_address = 8'h00; m1_address = 8'h00;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst.rdv0", 32'(m0_rdv[0]), 32'd0);
    chk("rst.wait0_idle", 32'(m0_wait[0]), 32'd1);
    step();
    reset_n = 1'b1;
    step();

    // Single m0 read.
    m0_read = 1; m0_address = 8'h10;
    @(negedge clk); chk("rd1.wait0", 32'(m0_wait[0]), 32'd0);
    step(); idle();
    @(negedge clk);
    chk("rd1.rdv0", 32'(m0_rdv[0]), 32'd1);
    chk("rd1.data", m0_rdata[0], 32'hDEADBEEF);
    chk("rd1.rdv1", 32'(m1_rdv[0]), 32'd0);
    step();
    @(negedge clk); chk("rd1.rdv0_once", 32'(m0_rdv[0]), 32'd0);

    // m1 partial write, then read back.
    m1_write = 1; m1_address = 8'h20; m1_writedata = 32'hAABBCCDD; m1_byteenable = 4'h3;
    step(); idle();
    m1_read = 1;
    step(); idle();
    @(negedge clk);
    chk("bw.rdv1", 32'(m1_rdv[0]), 32'd1);
    chk("bw.data", m1_rdata[0], 32'h1122CCDD);
    step();

    // Starvation: m0 reads every cycle, m1 holds a write request.
    m0_read = 1; m0_address = 8'h05;
    m1_write = 1; m1_address = 8'h30; m1_writedata = 32'h55; m1_byteenable = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("starve4.m1.c%0d", c), 32'(m1_wait[0]), 32'(!(c == 4 || c == 9)));
      chk($sformatf("starve4.m0.c%0d", c), 32'(m0_wait[0]), 32'(c == 4 || c == 9));
      chk($sformatf("starve1.m1.c%0d", c), 32'(m1_wait[1]), 32'(c % 2 == 0));
      step();
    end
    idle(); step();

    // Interleaved reads: m0 then m1.
    m0_read = 1; m0_address = 8'h01;
    step(); idle();
    m1_read = 1; m1_address = 8'h02;
    @(negedge clk);
    chk("il.rdv0", 32'(m0_rdv[0]), 32'd1);
    chk("il.rdv1_a", 32'(m1_rdv[0]), 32'd0);
    chk("il.data0", m0_rdata[0], init_word(1));
    step(); idle();
    @(negedge clk);
    chk("il.rdv1", 32'(m1_rdv[0]), 32'd1);
    chk("il.rdv0_b", 32'(m0_rdv[0]), 32'd0);
    chk("il.data1", m1_rdata[0], init_word(2));
    step();

    // Same-address race.
    m0_read = 1; m0_address = 8'h40;
    m1_write = 1; m1_address = 8'h40; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("race.wait0", 32'(m0_wait[0]), 32'd0);
    chk("race.wait1", 32'(m1_wait[0]), 32'd1);
    step(); m0_read = 0;
    @(negedge clk);
    chk("race.wait1_b", 32'(m1_wait[0]), 32'd0);
    chk("race.old", m0_rdata[0], init_word('h40));
    step(); idle();
    m1_read = 1;
    step(); idle();
    @(negedge clk); chk("race.new", m1_rdata[0], 32'h12345678);
    step();

    // Reset asserted the cycle after a read is accepted.
    m0_read = 1; m0_address = 8'h10;
    step(); idle();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("rstmid.rdv0", 32'(m0_rdv[0]), 32'd0);
      step();
    end
    reset_n = 1'b1;
    @(negedge clk); chk("rstmid.rdv0_rel", 32'(m0_rdv[0]), 32'd0);
    step();
    m0_read = 1;
    step(); idle();
    @(negedge clk);
    chk("rstmid.fresh_rdv", 32'(m0_rdv[0]), 32'd1);
    chk("rstmid.fresh_data", m0_rdata[0], 32'hDEADBEEF);
    step();

    // Random traffic on a narrow address window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      int k0, k1;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      m0_read  = (k0 == 1); m0_write = (k0 == 2);
      m1_read  = (k1 == 1) || (k1 == 3); m1_write = (k1 == 2);
      m0_address = 8'($urandom_range(0, 7));
      m1_address = 8'($urandom_range(0, 7));
      m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
      m0_writedata = $urandom; m1_writedata = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        idle(); reset_n = 1'b0; step(); reset_n = 1'b1;
      end
      step();
    end
    idle();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_miss_ram_arbiter.md
# tlb_miss_ram_arbiter

Two-master arbiter that shares port s1 of the 256 x 32 on-chip TLB-miss handler RAM between the Nios II instruction master (m0) and data master (m1). m0 has fixed priority, with a bounded starvation guarantee for m1. The block issues one RAM access per cycle, steers write data and byte enables, and returns read data with a `readdatavalid` strobe that accounts for the RAM's 1-cycle read latency. Port s2 of the RAM is not touched.

## Interface
Parameters:
- `ADDR_W`, 8, RAM word-address width (256 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W/8`)
- `STARVE_LIMIT`, 4, consecutive denied cycles after which m1 is forced a grant; legal range 1..255

Ports:
- `clk`  in  1  sole clock; drives the RAM port clock too
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_address` / `m1_address`  in  `ADDR_W`  word address
- `m0_read` / `m1_read`  in  1  read request
- `m0_write` / `m1_write`  in  1  write request; read and write are never both high on one master
- `m0_byteenable` / `m1_byteenable`  in  `BE_W`  write byte lanes
- `m0_writedata` / `m1_writedata`  in  `DATA_W`  write data
- `m0_waitrequest` / `m1_waitrequest`  out  1  high = request not accepted this cycle
- `m0_readdata` / `m1_readdata`  out  `DATA_W`  read data
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  read data valid strobe
- `ram_address`  out  `ADDR_W`  to RAM `address`
- `ram_chipselect`  out  1  to RAM `chipselect`
- `ram_write`  out  1  to RAM `write`
- `ram_byteenable`  out  `BE_W`  to RAM `byteenable`
- `ram_writedata`  out  `DATA_W`  to RAM `writedata`
- `ram_clken`  out  1  to RAM `clken`; constant 1
- `ram_readdata`  in  `DATA_W`  from RAM `readdata`; valid the cycle after address is presented

## Operation
- Request: `reqN = mN_read | mN_write`.
- Grant is computed combinationally each cycle:
  - `force1 = req1 & (starve_cnt == STARVE_LIMIT)`
  - `grant1 = req1 & (~req0 | force1)`
  - `grant0 = req0 & ~force1`
  - At most one grant per cycle.
- `mN_waitrequest = ~grantN`. The signal is also high when master N is idle.
- RAM drive:
  - `ram_chipselect = grant0 | grant1`
  - `ram_address`, `ram_byteenable`, `ram_writedata` and `ram_write` are muxed from the granted master.
  - With no grant, these outputs are driven from m0 and `ram_write = 0`.
- Writes complete in the acceptance cycle. Nothing is returned.
- Reads: on acceptance, registers `rd_vld <= 1` and `rd_owner <= N`.
  - Next cycle: `mN_readdatavalid = rd_vld & (rd_owner == N)`.
  - `m0_readdata` and `m1_readdata` both carry `ram_readdata`, unconditionally.
- Starvation counter `starve_cnt`, 8 bits:
  - increments when `req1 & ~grant1`, saturating at `STARVE_LIMIT`
  - clears when `grant1` or `~req1`
- Back-to-back accepts are allowed every cycle. Up to one read is in flight; it never stalls a new accept.
- Simultaneous m0 read and m1 write to the same address: they are serialized by the grant, and the second access sees the result of the first.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `rd_vld = 0`, `rd_owner = 0`, `starve_cnt = 0`
  - Consequently `m0_readdatavalid = m1_readdatavalid = 0`.
  - Waitrequests follow the combinational grant, so they are high while idle.
  - `ram_clken = 1` always.
- Reset released mid-read: the pending `readdatavalid` is lost and must not fire after release.
- Accept at edge T (waitrequest low in cycle T-1 to T): RAM samples the address at T; `readdatavalid` and data are presented in cycle T to T+1. Read latency is 1, throughput is 1 per cycle.
- Under continuous m0 traffic, m1 is accepted within `STARVE_LIMIT + 1` cycles of asserting its request.
- All outputs except `readdatavalid` are combinational from inputs and `starve_cnt`. No combinational path from `ram_readdata` to any waitrequest.

## Test plan
- Single read: preload word 0x10 = 0xDEADBEEF; m0 reads 0x10 with m1 idle -> `m0_waitrequest` low in the request cycle; `m0_readdatavalid` high for exactly 1 cycle next with 0xDEADBEEF; `m1_readdatavalid` stays 0.
- Byte write: word 0x20 = 0x11223344; m1 writes 0xAABBCCDD with byteenable 0x3, then reads 0x20 -> read returns 0x1122CCDD.
- Starvation: m0 reads continuously while m1 requests a write of 0x55 at 0x30 from cycle 0 -> m1 denied cycles 0..3, accepted in cycle 4, m0 denied that cycle only. Repeat with `STARVE_LIMIT = 1` -> m1 accepted every 2nd cycle.
- Interleaved reads: m0 reads 0x01 and m1 reads 0x02 on consecutive accepts -> each `readdatavalid` lands on its owner only, one cycle after its own accept, with no cross-delivery.
- Same-address race: m0 reads 0x40 and m1 writes 0x12345678 to 0x40 in the same cycle -> m0 is granted first and returns the old value; m1's write lands in the next cycle; a later read returns 0x12345678.
- Reset mid-op: assert `reset_n` low in the cycle after a read is accepted -> no `readdatavalid` at any time; after release, `starve_cnt = 0` and a fresh m0 read completes with 1-cycle latency.
